// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART serializer, plus a small drain FSM that
// launches one byte at a time and waits for the serializer's busy/done handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   wr_en      push request from the producer
//   wr_data    byte to push
//   full       FIFO holds 2**ADDR_WIDTH entries (registered)
//   empty      FIFO holds 0 entries (registered)
//   count      current occupancy, 0..2**ADDR_WIDTH (registered)
//   overflow   sticky: a push was dropped because the FIFO was full
//   start_trig one-cycle launch pulse to the serializer
//   tx_data    byte presented to the serializer, held until the next launch
//   tx_busy    serializer busy, rises the cycle after start_trig
//   tx_done    serializer end-of-stop-bit pulse, seen while tx_busy is high
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  start_trig,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CountMax = (ADDR_WIDTH + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q, start_trig_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  logic pop, push, drop;

  // A launch pops the head; a push while full is only legal when that pop frees a slot
  // on the same edge, so the occupancy stays at its maximum.
  always_comb begin
    pop  = (state_q == StIdle) && !empty_q && !tx_busy;
    push = wr_en && (!full_q || pop);
    drop = wr_en && full_q && !pop;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pop)     state_d = StWaitBusy;
      StWaitBusy: if (tx_busy) state_d = StWaitDone;
      StWaitDone: if (tx_done) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      start_trig_q <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      full_q       <= (count_d == CountMax);
      empty_q      <= (count_d == '0);
      start_trig_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q];
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign start_trig = start_trig_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, start_trig;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done = 1'b0;
  logic       ser_busy = 1'b0;
  logic       hold = 1'b0;
  int         ser_len = 3;

  assign tx_busy = ser_busy | hold;

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .start_trig(start_trig),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, a flag for "a byte is out on the wire",
  // expected launches pushed to the scoreboard queue sb.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         m_inflight = 0;
  bit         m_ovf = 0;
  bit         exp_trig = 0;
  logic [7:0] exp_txd = 8'h00;

  initial begin
    bit         m_pop, was_full;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        sb.delete();
        m_inflight = 0;
        m_ovf      = 0;
        exp_trig   = 0;
        exp_txd    = 8'h00;
      end else begin
        m_pop    = !m_inflight && mq.size() > 0 && !tx_busy;
        was_full = (mq.size() == Depth);
        if (tx_done) m_inflight = 0;
        if (m_pop) begin
          b = mq.pop_front();
          sb.push_back(b);
          exp_txd    = b;
          m_inflight = 1;
        end
        if (wr_en) begin
          if (!was_full || m_pop) mq.push_back(wr_data);
          else m_ovf = 1;
        end
        exp_trig = m_pop;
      end
      #2;
      chk("start_trig", start_trig, exp_trig);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == Depth);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("tx_data", tx_data, exp_txd);
    end
  end

  // Monitor: every launch must carry the next byte the model expects.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (start_trig) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_unexpected: got %0h expected none at %0t", tx_data, $time);
        end else begin
          e = sb.pop_front();
          chk("launch_byte", tx_data, e);
        end
      end
    end
  end

  // Serializer model: busy the cycle after start_trig, done pulse while still busy.
  initial begin
    int len;
    forever begin
      @(posedge clk);
      #1;
      if (start_trig) begin
        len      = ser_len;
        ser_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done  = 1'b0;
        ser_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || sb.size() != 0 || ser_busy || start_trig) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", mq.size());
    end
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_txdata", tx_data, 0);
    reset = 1'b0;
    tick();

    // Single byte
    push(8'hA5);
    chk("single_trig", start_trig, 0);
    tick();
    chk("single_launch", start_trig, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_empty", empty, 1);
    drain();

    // Burst with serializer held busy, then full-plus-pop, then overflow in WAIT_DONE
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("burst_full", full, 1);
    chk("burst_count", count, 16);
    ser_len = 8;
    hold    = 1'b0;
    push(8'h55);
    chk("fullpop_count", count, 16);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_trig", start_trig, 1);
    tick();
    tick();
    tick();
    push(8'hFF);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    drain();
    chk("ovf_sticky", overflow, 1);

    // Reset while waiting for done with 3 entries queued
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold  = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    hold = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_count", count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    repeat (15) tick();
    push(8'h3C);
    drain();

    // Random interleaved traffic across many pointer wraps
    for (int c = 0; c < 400; c++) begin
      ser_len = $urandom_range(1, 5);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of the stored and transmitted data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, FIFO depth = 2**ADDR_WIDTH entries (16).
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1, push request from the producer.
REQ-006 SHALL have port wr_data, input, DATA_WIDTH, byte to push.
REQ-007 SHALL have port full, output, 1, FIFO holds 2**ADDR_WIDTH entries.
REQ-008 SHALL have port empty, output, 1, FIFO holds 0 entries.
REQ-009 SHALL have port count, output, ADDR_WIDTH+1, current occupancy, 0..2**ADDR_WIDTH.
REQ-010 SHALL have port overflow, output, 1, sticky flag for a dropped write.
REQ-011 SHALL have port start_trig, output, 1, one-cycle launch pulse to the serializer.
REQ-012 SHALL have port tx_data, output, DATA_WIDTH, byte presented to the serializer.
REQ-013 SHALL have port tx_busy, input, 1, serializer busy, rises the cycle after start_trig and stays high through the stop bit.
REQ-014 SHALL have port tx_done, input, 1, one-cycle pulse at the end of the stop bit, while tx_busy is still high.

Function
REQ-015 SHALL store entries in a circular buffer with ADDR_WIDTH-bit read and write pointers that wrap from 2**ADDR_WIDTH-1 to 0.
REQ-016 SHALL accept a push when wr_en=1 and full=0, writing wr_data at the write pointer and incrementing it.
REQ-017 SHALL accept a push when wr_en=1, full=1 and a pop occurs in the same cycle, so count stays at maximum.
REQ-018 SHALL drop a push when wr_en=1, full=1 and no pop occurs, leave pointers and count unchanged, and set overflow=1.
REQ-019 SHALL keep overflow high until reset.
REQ-020 SHALL register count, full and empty, updating them on the clock edge that performs the push or pop (push only +1, pop only -1, both unchanged).
REQ-021 SHALL implement a drain FSM with states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-022 In IDLE, when empty=0 and tx_busy=0, the FSM SHALL pop the head entry, register it onto tx_data, pulse start_trig high for exactly one cycle, and enter WAIT_BUSY, all on the same edge.
REQ-023 In WAIT_BUSY, the FSM SHALL move to WAIT_DONE when tx_busy=1.
REQ-024 In WAIT_DONE, the FSM SHALL move to IDLE when tx_done=1.
REQ-025 SHALL re-check tx_busy=0 in IDLE before the next launch, giving at least one cycle between tx_done and the next start_trig.
REQ-026 SHALL hold tx_data stable from the start_trig cycle until the next launch.
REQ-027 Latency: a push into an empty FIFO with the FSM in IDLE and tx_busy=0 SHALL produce start_trig=1 in the cycle after the push edge, so empty is observed as 1 at most one cycle.
REQ-028 SHALL never assert start_trig outside IDLE or while empty=1.
REQ-029 SHALL produce a bit-exact byte order out equal to the push order, including across pointer wrap.

Reset
REQ-030 On reset=1 at a clock edge, SHALL clear pointers, set count=0, empty=1, full=0, overflow=0, start_trig=0, tx_data=0 and the FSM to IDLE.
REQ-031 Reset mid-transfer SHALL discard all FIFO contents and the in-flight handshake state.
REQ-032 After a mid-transfer reset, SHALL issue no start_trig until a new push occurs and tx_busy=0.

Verification
REQ-033 Single byte: push 0xA5 into an idle FIFO -> start_trig for 1 cycle on the next cycle, tx_data=0xA5, count returns to 0, empty=1.
REQ-034 Burst: push 0x00..0x0F back-to-back with the serializer model busy -> full=1 and count=16 after 16 pushes, then 16 start_trig pulses, each only after the prior tx_done, in order 0x00..0x0F.
REQ-035 Overflow: with the FIFO full and the FSM in WAIT_DONE, push 0xFF -> dropped, overflow=1, count=16, 0xFF never transmitted.
REQ-036 Full plus simultaneous pop: with the FIFO full, push 0x55 on the launch cycle -> accepted, count stays 16, overflow=0, 0x55 emitted last.
REQ-037 Wrap: 40 pushes/pops interleaved -> output sequence equals input sequence and count never exceeds 16.
REQ-038 Reset in WAIT_DONE with 3 entries queued -> count=0, empty=1, no start_trig after tx_done, next push transmits normally.
